// File: rtl/mul32x32_seq_ctrl.sv
// Sequential 32x32 unsigned multiplier controller: feeds one byte of b per cycle to an
// external combinational 32x8 multiplier and shift-accumulates the 40-bit partial products.
module mul32x32_seq_ctrl #(
  parameter bit SKIP_ZERO_BYTES = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] mul_a,
  output logic [7:0]  mul_b,
  input  logic [39:0] mul_y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] product,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        upper_zero;

  // All bytes of b above the one currently in flight are zero.
  always_comb begin
    upper_zero = 1'b0;
    unique case (idx_q)
      2'd0:    upper_zero = (b_q[31:8] == 24'd0);
      2'd1:    upper_zero = (b_q[31:16] == 16'd0);
      2'd2:    upper_zero = (b_q[31:24] == 8'd0);
      default: upper_zero = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    a_d       = a_q;
    b_d       = b_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    mul_a     = 32'd0;
    mul_b     = 8'd0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          acc_d   = 64'd0;
          idx_d   = 2'd0;
          state_d = StRun;
        end
      end
      StRun: begin
        busy  = 1'b1;
        mul_a = a_q;
        mul_b = b_q[{idx_q, 3'b000} +: 8];
        acc_d = acc_q + (64'(mul_y) << {idx_q, 3'b000});
        if (idx_q == 2'd3 || (SKIP_ZERO_BYTES && upper_zero)) begin
          state_d = StDone;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      StDone: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign product = acc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= 2'd0;
      acc_q   <= 64'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

endmodule

// File: tb/tb_mul32x32_seq_ctrl.sv
// Scoreboard bench: instance 0 skips zero bytes, instance 1 always runs four cycles; both are
// driven by an ideal combinational 32x8 multiplier model.
module tb_mul32x32_seq_ctrl;

  typedef struct packed {
    logic [63:0] prod;
    logic [31:0] seq;
    logic [2:0]  lat;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [31:0] in_a      [2];
  logic [31:0] in_b      [2];
  logic [31:0] mul_a     [2];
  logic [7:0]  mul_b     [2];
  logic [39:0] mul_y     [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [63:0] product   [2];
  logic        busy      [2];

  exp_t exp_q[2][$];
  int   checks;
  int   failures;
  int   cyc;

  assign mul_y[0] = 40'(mul_a[0]) * 40'(mul_b[0]);
  assign mul_y[1] = 40'(mul_a[1]) * 40'(mul_b[1]);

  mul32x32_seq_ctrl #(.SKIP_ZERO_BYTES(1'b1)) u_skip (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .a(in_a[0]),
    .b(in_b[0]), .mul_a(mul_a[0]), .mul_b(mul_b[0]), .mul_y(mul_y[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .product(product[0]), .busy(busy[0])
  );

  mul32x32_seq_ctrl #(.SKIP_ZERO_BYTES(1'b0)) u_noskip (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .a(in_a[1]),
    .b(in_b[1]), .mul_a(mul_a[1]), .mul_b(mul_b[1]), .mul_y(mul_y[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .product(product[1]), .busy(busy[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: tracks accept time, RUN-cycle mul_b bytes and pops on each output handshake.
  initial begin
    int          acc_cyc   [2];
    int          first_cyc [2];
    int          run_cnt   [2];
    logic [31:0] seq       [2];
    bit          seen      [2];
    exp_t        e;
    for (int k = 0; k < 2; k++) begin
      acc_cyc[k] = 0; first_cyc[k] = 0; run_cnt[k] = 0; seq[k] = 0; seen[k] = 0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (rst) begin
          run_cnt[k] = 0;
          seq[k]     = 0;
          seen[k]    = 0;
        end else begin
          if (in_valid[k] && in_ready[k]) begin
            acc_cyc[k] = cyc;
            run_cnt[k] = 0;
            seq[k]     = 0;
          end
          if (busy[k] && !out_valid[k]) begin
            if (run_cnt[k] < 4) seq[k] = seq[k] | (32'(mul_b[k]) << (8 * run_cnt[k]));
            run_cnt[k]++;
          end
          if (out_valid[k] && !seen[k]) begin
            first_cyc[k] = cyc;
            seen[k]      = 1'b1;
          end
          if (out_valid[k] && out_ready[k]) begin
            if (exp_q[k].size() == 0) begin
              chk($sformatf("unexpected_output[%0d]", k), product[k], 64'hx);
            end else begin
              e = exp_q[k].pop_front();
              chk($sformatf("product[%0d]", k), product[k], e.prod);
              chk($sformatf("latency[%0d]", k), 64'(first_cyc[k] - acc_cyc[k] - 1),
                  64'(e.lat));
              chk($sformatf("run_cycles[%0d]", k), 64'(run_cnt[k]), 64'(e.lat));
              chk($sformatf("mul_b_seq[%0d]", k), 64'(seq[k]), 64'(e.seq));
            end
            seen[k] = 1'b0;
          end
        end
      end
    end
  end

  task automatic issue(input int k, input logic [31:0] av, input logic [31:0] bv,
                       input logic [63:0] prod, input logic [2:0] lat, input logic [31:0] sq);
    int n;
    exp_t e;
    e.prod = prod;
    e.seq  = sq;
    e.lat  = lat;
    exp_q[k].push_back(e);
    in_a[k]     = av;
    in_b[k]     = bv;
    in_valid[k] = 1'b1;
    n = 0;
    while (!in_ready[k] && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) chk("accept_timeout", 64'(in_ready[k]), 64'd1);
    @(posedge clk);
    #1;
    in_valid[k] = 1'b0;
  endtask

  task automatic drain(input int k);
    int n;
    n = 0;
    while (exp_q[k].size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) chk("drain_timeout", 64'(exp_q[k].size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_valid[k]  = 1'b0;
      in_a[k]      = 32'd0;
      in_b[k]      = 32'd0;
      out_ready[k] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready[0]), 64'd1);
    chk("rst_out_valid", 64'(out_valid[0]), 64'd0);
    chk("rst_product", product[0], 64'd0);
    chk("rst_busy", 64'(busy[0]), 64'd0);
    chk("rst_mul_a", 64'(mul_a[0]), 64'd0);
    chk("rst_mul_b", 64'(mul_b[0]), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    issue(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 3'd4, 32'hFFFFFFFF);
    drain(0);
    issue(0, 32'h12345678, 32'h000000FF, 64'h0000001222222188, 3'd1, 32'h000000FF);
    drain(0);
    issue(1, 32'h12345678, 32'h000000FF, 64'h0000001222222188, 3'd4, 32'h000000FF);
    drain(1);
    issue(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 3'd4, 32'hFFFFFFFF);
    drain(1);
    issue(0, 32'hDEADBEEF, 32'h01000000, 64'h00DEADBEEF000000, 3'd4, 32'h01000000);
    drain(0);

    // Backpressure in DONE with a competing operand pair already presented.
    out_ready[0] = 1'b0;
    issue(0, 32'h00010002, 32'h00000300, 64'h0000000003000600, 3'd2, 32'h00000300);
    n = 0;
    while (!out_valid[0] && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 20) chk("done_timeout", 64'(out_valid[0]), 64'd1);
    in_a[0]     = 32'h00000010;
    in_b[0]     = 32'h00000010;
    in_valid[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("bp_out_valid", 64'(out_valid[0]), 64'd1);
      chk("bp_product", product[0], 64'h0000000003000600);
      chk("bp_in_ready", 64'(in_ready[0]), 64'd0);
    end
    out_ready[0] = 1'b1;
    issue(0, 32'h00000010, 32'h00000010, 64'h0000000000000100, 3'd1, 32'h00000010);
    drain(0);

    // Reset mid-run at idx 2: the operation is dropped with no output.
    in_a[0]     = 32'hDEADBEEF;
    in_b[0]     = 32'h01000000;
    in_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    chk("run_mul_a", 64'(mul_a[0]), 64'hDEADBEEF);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("run_busy_idx2", 64'(busy[0]), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_in_ready", 64'(in_ready[0]), 64'd1);
    chk("midrst_out_valid", 64'(out_valid[0]), 64'd0);
    chk("midrst_product", product[0], 64'd0);
    chk("midrst_busy", 64'(busy[0]), 64'd0);
    chk("midrst_mul_b", 64'(mul_b[0]), 64'd0);

    issue(0, 32'h00000003, 32'h00000005, 64'd15, 3'd1, 32'h00000005);
    drain(0);
    issue(0, 32'hFFFFFFFF, 32'h00000000, 64'd0, 3'd1, 32'h00000000);
    drain(0);
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
